// File: rtl/stall_pipe_pkg.sv
// Shared defaults for the stall_pipe delay line.
package stall_pipe_pkg;
  localparam int DEF_WIDTH   = 16;
  localparam int DEF_LATENCY = 3;
endpackage

// File: rtl/pipe_stage.sv
// One valid/data register pair of the stalling delay line.
module pipe_stage
  import stall_pipe_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             load,
  input  logic             v_in,
  input  logic [WIDTH-1:0] d_in,
  output logic             v,
  output logic [WIDTH-1:0] d
);

  // Data is enable-gated so bubbles never toggle the payload register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v <= 1'b0;
      d <= '0;
    end else if (flush) begin
      v <= 1'b0;
    end else if (load) begin
      v <= v_in;
      if (v_in) begin
        d <= d_in;
      end
    end
  end

endmodule

// File: rtl/stall_pipe_checker.sv
// Simulation-only invariants of stall_pipe: occupancy tracking and flush gating.
module stall_pipe_checker
  import stall_pipe_pkg::*;
#(
  parameter int LATENCY = DEF_LATENCY,
  parameter int CW      = $clog2(LATENCY + 1)
) (
  input logic               clk,
  input logic               rst,
  input logic               flush,
  input logic               accept,
  input logic [LATENCY-1:0] v,
  input logic [CW-1:0]      count
);

  count_matches_occupancy : assert property (
    @(posedge clk) disable iff (rst) count == CW'($countones(v)));

  no_accept_under_flush : assert property (
    @(posedge clk) disable iff (rst) !(flush && accept));

endmodule

// File: rtl/stall_pipe.sv
// Data+valid delay line with per-stage stall, bubble collapse, flush and occupancy.
module stall_pipe
  import stall_pipe_pkg::*;
#(
  parameter  int WIDTH   = DEF_WIDTH,
  parameter  int LATENCY = DEF_LATENCY,
  localparam int CW      = $clog2(LATENCY + 1)
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             flush_in,
  input  logic             valid_in,
  input  logic [WIDTH-1:0] data_in,
  output logic             ready_out,
  output logic             valid_out,
  output logic [WIDTH-1:0] data_out,
  input  logic             ready_in,
  output logic [CW-1:0]    count_out
);

  logic [LATENCY-1:0] v;
  logic [LATENCY-1:0] load;
  logic [WIDTH-1:0]   d [LATENCY];
  logic [CW-1:0]      count;
  logic               accept;
  logic               deliver;

  // A stage may load when it is empty or its successor is moving on.
  always_comb begin
    load = '0;
    load[LATENCY-1] = !v[LATENCY-1] | ready_in;
    for (int i = LATENCY - 2; i >= 0; i--) begin
      load[i] = !v[i] | load[i+1];
    end
  end

  assign ready_out = load[0] & !flush_in & !rst_in;
  assign accept    = valid_in & ready_out;
  assign deliver   = v[LATENCY-1] & ready_in;

  for (genvar g = 0; g < LATENCY; g++) begin : g_stage
    logic             src_v;
    logic [WIDTH-1:0] src_d;
    if (g == 0) begin : g_head
      assign src_v = valid_in;
      assign src_d = data_in;
    end else begin : g_body
      assign src_v = v[g-1];
      assign src_d = d[g-1];
    end
    pipe_stage #(.WIDTH(WIDTH)) u_stage (
      .clk   (clk_in),
      .rst   (rst_in),
      .flush (flush_in),
      .load  (load[g]),
      .v_in  (src_v),
      .d_in  (src_d),
      .v     (v[g]),
      .d     (d[g])
    );
  end

  // Occupancy tracks handshakes; a deliver in a flush cycle still completes downstream.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      count <= '0;
    end else if (flush_in) begin
      count <= '0;
    end else begin
      count <= count + CW'(accept) - CW'(deliver);
    end
  end

  assign valid_out = v[LATENCY-1];
  assign data_out  = d[LATENCY-1];
  assign count_out = count;

  stall_pipe_checker #(.LATENCY(LATENCY), .CW(CW)) u_checker (
    .clk    (clk_in),
    .rst    (rst_in),
    .flush  (flush_in),
    .accept (accept),
    .v      (v),
    .count  (count)
  );

endmodule

// File: doc/stall_pipe.md
Name: stall_pipe

Overview:
- Parametrised data+valid delay line with ready/valid backpressure; successor to the fixed-latency valid-only pipe.
- Carries a WIDTH-bit payload through LATENCY register stages.
- Stalls stage-by-stage when downstream deasserts ready, and collapses bubbles so empty stages fill under stall.
- Adds a synchronous flush and an occupancy count; used to align payloads with fixed-latency datapaths (rasteriser, memory read) whose consumers can stall.

Parameters:
- WIDTH, 16, payload width in bits (>=1).
- LATENCY, 3, number of register stages; minimum input-to-output latency in cycles (>=1).
- CW, $clog2(LATENCY+1), derived (localparam); occupancy counter width.

Ports:
- clk_in  input  1  clock; all state updates on rising edge.
- rst_in  input  1  asynchronous, active-high reset.
- flush_in  input  1  synchronous flush; drops all in-flight entries.
- valid_in  input  1  upstream payload valid.
- data_in  input  WIDTH  upstream payload.
- ready_out  output  1  pipe can accept this cycle (upstream handshake).
- valid_out  output  1  downstream payload valid.
- data_out  output  WIDTH  downstream payload.
- ready_in  input  1  downstream accepts this cycle.
- count_out  output  CW  number of valid entries currently held (0..LATENCY).

Behaviour:
- State per stage i (0..LATENCY-1): v[i] (1 bit) and d[i] (WIDTH). Stage 0 is the input stage; stage LATENCY-1 drives valid_out/data_out directly (registered outputs, no combinational path from data_in).
- Reset (async, rst_in=1): all v[i]=0, d[i]=0, count=0. Outputs during reset: valid_out=0, data_out=0, count_out=0. ready_out=0 while rst_in=1.
- Load enables, combinational, computed from the last stage backward:
  - load[LATENCY-1] = !v[LATENCY-1] | ready_in.
  - load[i] = !v[i] | load[i+1].
- ready_out = load[0] & !flush_in & !rst_in.
- Transfer rules per edge, no flush:
  - Stage i>0 with load[i]=1: v[i] <= v[i-1]; d[i] <= d[i-1] only when v[i-1]=1. Stage data registers are enable-gated and do not toggle on bubbles.
  - Stage 0 with load[0]=1: v[0] <= valid_in; d[0] <= data_in when valid_in=1.
  - Stage with load[i]=0: holds v[i] and d[i].
- Handshakes:
  - Accept when valid_in & ready_out. Deliver when valid_out & ready_in.
  - Upstream must hold data_in stable while valid_in=1 & ready_out=0. The block does not check this.
- Latency: with ready_in held high, an item accepted at edge t appears on valid_out after edge t+LATENCY-1, i.e. LATENCY cycles of register delay. This matches the valid-only pipe when never stalled.
- Stall: with ready_in=0 and stage LATENCY-1 full, upstream stages keep advancing into empty stages. ready_out drops only when all LATENCY stages are full.
- Simultaneous accept and deliver when full: allowed. ready_in=1 propagates load through the chain in the same cycle, so full throughput is sustained at count=LATENCY.
- count: count <= count + accept - deliver, evaluated each edge. It never exceeds LATENCY and never underflows.
- Flush (flush_in=1 at an edge):
  - All v[i] <= 0 and count <= 0. Flush takes precedence over load/accept.
  - valid_out is not gated by flush_in. A deliver occurring in the flush cycle counts as completed downstream.
  - ready_out=0 during flush, so no item is accepted and dropped silently.
  - d[i] are not required to clear.
- Reset mid-operation: all entries dropped immediately (asynchronous). Normal operation resumes on the first edge after rst_in falls.
- Asserts (simulation only):
  - count_out equals popcount(v).
  - No accept while flush_in=1.

Decomposition:
- No shared package types required; the payload is a plain WIDTH vector.
- Optional sub-module pipe_stage (one v/d register pair with load and flush inputs), instantiated LATENCY times via generate. Load-chain and count logic stay in the top.

Test Plan:
- Free-flow: LATENCY=3, WIDTH=16, ready_in=1, send 0x0001..0x0008 back-to-back -> each appears exactly 3 cycles after acceptance, in order, with no gaps; count_out steady at 3.
- Bubble collapse: send 0xA1, idle 1 cycle, send 0xA2, then ready_in=0 -> pipe fills to count_out=2 in adjacent last stages. ready_out stays 1 until a third item fills, then 0.
- Full with simultaneous accept and deliver: fill to 3 (0xB1,0xB2,0xB3), then ready_in=1 and valid_in=1 with 0xB4 -> 0xB1 delivered and 0xB4 accepted on the same edge; count_out stays 3.
- Flush: 2 items in flight, assert flush_in for 1 cycle with valid_in=1 -> ready_out=0 that cycle; count_out=0 and valid_out=0 next cycle; the flushed items never appear.
- Async reset mid-stream: 3 items in flight, pulse rst_in between clock edges -> valid_out and count_out go 0 without waiting for an edge; the first post-reset item arrives with latency 3.
- LATENCY=1 build: ready_in toggling 1,0,1 with a continuous stream 0xC0.. -> no item lost or duplicated; ready_out equals !valid_out | ready_in.
